// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg: shared types and constants for the sipo_ctrl frame controller.
//   state_t   - FSM state encoding (IDLE / SHIFT / PARITY)
//   WIDTH_MIN - smallest supported frame width
//   WIDTH_MAX - largest supported frame width
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage : sipo_ctrl_pkg

// File: rtl/sipo_shreg.sv
// sipo_shreg: WIDTH-bit shift-right register, serial entry at the MSB.
// Ports:
//   i_clk      - clock, rising edge
//   i_rst_n    - asynchronous active-low reset (clears the register)
//   i_shift_en - shift one place toward bit 0 this edge
//   i_sin      - serial bit entering bit WIDTH-1
//   o_word     - value the register holds after the coming edge
//                (shifted word when enabled, current contents otherwise)
module sipo_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_shift_en,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    assign w_next = {i_sin, r_q[WIDTH-1:1]};

    // Look-ahead output lets the controller capture a completed word in the
    // same edge that shifts the last bit in.
    assign o_word = i_shift_en ? w_next : r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= w_next;
        end
    end

endmodule : sipo_shreg

// File: rtl/sipo_ctrl.sv
// sipo_ctrl: frame-level controller for a bit-serial to word-parallel path.
// Gates a sipo_shreg with frame start / bit strobe, counts bits, and hands
// each completed word to a consumer through a one-word valid/ready holding
// register. Completion while the holder is full and not being drained drops
// the new word and pulses overrun.
// Build option: define SIPO_CTRL_PARITY_EN to append one even-parity bit per
// frame (PARITY state) and register parity_err alongside dout.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, abort          - frame start (IDLE only), synchronous frame abort
//   sin, sin_valid        - serial bit and its strobe
//   dout, dout_valid      - parallel word (first bit at dout[0]) and valid
//   dout_ready            - consumer accepts dout this cycle
//   busy                  - frame in progress
//   overrun               - one-cycle pulse when a completed word is dropped
//   parity_err            - parity result for dout (0 without parity)
module sipo_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_busy;
    logic             r_overrun;

    logic             w_shift_en;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;

    assign w_shift_en = (r_state == SHIFT) && sin_valid && !abort;

`ifdef SIPO_CTRL_PARITY_EN
    logic r_parity_err;
    // Word is already fully shifted in; the parity bit itself completes it.
    assign w_complete = (r_state == PARITY) && sin_valid && !abort;
    assign parity_err = r_parity_err;
`else
    assign w_complete = w_shift_en && (r_cnt == LAST);
    assign parity_err = 1'b0;
`endif

    sipo_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_shift_en (w_shift_en),
        .i_sin      (sin),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_CTRL_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;

            // Output holder: a completion may reuse the slot being drained
            // this same edge; otherwise it is dropped while the slot is full.
            if (w_complete) begin
                if (!r_dout_valid || dout_ready) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
`ifdef SIPO_CTRL_PARITY_EN
                    r_parity_err <= (^w_word) ^ sin;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (sin_valid) begin
                        if (r_cnt == LAST) begin
`ifdef SIPO_CTRL_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
`ifdef SIPO_CTRL_PARITY_EN
                PARITY: begin
                    if (abort || sin_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule : sipo_ctrl

// File: tb/tb_sipo_ctrl.sv
// tb_sipo_ctrl: self-checking bench for sipo_ctrl (WIDTH=8), directed frames
// followed by randomized traffic, compared against a frame-level model.
// Honours SIPO_CTRL_PARITY_EN the same way as the design.
module tb_sipo_ctrl;

    localparam int unsigned W = 8;
`ifdef SIPO_CTRL_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovr_seen = 0;
    int n_busy_cycles = 0;

    // frame-level reference state
    logic         m_busy;
    int           m_n;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    sipo_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_n = 0; m_acc = '0;
        m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    // One clock edge as seen from the frame level: collect bits, and on the
    // FL-th bit offer the assembled word to the one-deep output slot.
    task automatic model_step();
        logic done;
        logic perr;
        done = 1'b0;
        perr = 1'b0;
        if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1'b1; m_n = 0; m_acc = '0;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else if (sin_valid) begin
            if (m_n < W) m_acc[m_n] = sin;
            m_n++;
            if (m_n == FL) begin
                done = 1'b1;
                m_busy = 1'b0;
            end
        end
`ifdef SIPO_CTRL_PARITY_EN
        perr = (^m_acc) ^ sin;
`endif
        m_ovr = 1'b0;
        if (done) begin
            if (!m_valid || dout_ready) begin
                m_dout = m_acc; m_valid = 1'b1; m_perr = perr;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && dout_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("dout_valid", 32'(dout_valid), 32'(m_valid));
        check_eq("dout", 32'(dout), 32'(m_dout));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        check_eq("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    // Called at a negedge: apply inputs, take one edge, compare 1 time unit later.
    task automatic cycle(input logic st, input logic ab, input logic s,
                         input logic sv, input logic rdy);
        start = st; abort = ab; sin = s; sin_valid = sv; dout_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (overrun) n_ovr_seen++;
        if (busy) n_busy_cycles++;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic gap,
                              input logic rdy, input logic rdy_last, input logic pbit);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rdy);
        for (int i = 0; i < int'(W); i++) begin
            if (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
            cycle(1'b0, 1'b0, word[i], 1'b1,
                  (i == int'(FL) - 1) ? rdy_last : rdy);
        end
`ifdef SIPO_CTRL_PARITY_EN
        cycle(1'b0, 1'b0, pbit, 1'b1, rdy_last);
`else
        if (pbit) check_eq("pbit_unused", 32'(pbit), 32'(0));
`endif
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, consumer always ready
        n_busy_cycles = 0;
        send_frame(8'h4D, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("basic_dout", 32'(dout), 32'h4D);
        check_eq("basic_valid", 32'(dout_valid), 32'(1));
        check_eq("basic_busy_len", 32'(n_busy_cycles), 32'(FL));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("basic_valid_drop", 32'(dout_valid), 32'(0));

        // Gapped strobe
        send_frame(8'h4D, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("gap_dout", 32'(dout), 32'h4D);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure and overrun
        n_ovr_seen = 0;
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_dout", 32'(dout), 32'h4D);
        check_eq("ovr_count", 32'(n_ovr_seen), 32'(1));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_drain", 32'(dout_valid), 32'(0));

        // Completion coincident with a transfer
        n_ovr_seen = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("b2b_dout", 32'(dout), 32'h3C);
        check_eq("b2b_valid", 32'(dout_valid), 32'(1));
        check_eq("b2b_ovr", 32'(n_ovr_seen), 32'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after four bits; coincident start is ignored
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_valid", 32'(dout_valid), 32'(0));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("abort_idle_start", 32'(busy), 32'(0));

        // Asynchronous reset mid-frame (after a word is held)
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_dout", 32'(dout), 32'(0));
        check_eq("rst_valid", 32'(dout_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("post_rst_dout", 32'(dout), 32'h96);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_CTRL_PARITY_EN
        send_frame(8'h4D, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("par_ok_dout", 32'(dout), 32'h4D);
        check_eq("par_ok_err", 32'(parity_err), 32'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h4D, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("par_bad_dout", 32'(dout), 32'h4D);
        check_eq("par_bad_err", 32'(parity_err), 32'(1));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sipo_ctrl

// File: doc/sipo_ctrl.md
# sipo_ctrl

Frame-level controller that sequences a WIDTH-bit right-shifting serial-in/parallel-out register. It sits between a bit-serial source and a word-wide consumer. It gates shifting with a frame start and a per-bit strobe, and counts bits. It hands each completed word to the consumer over a valid/ready interface, with a one-word output holding register so the next frame can shift in while the previous word waits.

## Interface
- WIDTH, 8, data bits per frame; legal range 2..32.
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame start pulse; honoured only in IDLE.
- abort  input  1  synchronous frame abort; discards the partial word.
- sin  input  1  serial data bit.
- sin_valid  input  1  bit strobe; sin is sampled only when high.
- dout  output  WIDTH  parallel word; first-received bit at dout[0].
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  frame in progress (state ≠ IDLE).
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- parity_err  output  1  parity result for the current dout word; tied 0 without parity.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY only when parity is compiled in).
- IDLE → SHIFT on start. The bit counter clears and the shift register is not cleared. sin_valid in the same cycle as start is ignored.
- In SHIFT, each cycle with sin_valid high does the following:
  - sin enters the MSB of the shift register.
  - All other bits move one place toward bit 0.
  - The counter increments.
- Cycles with sin_valid low hold all state.
- Last data bit (counter == WIDTH-1 with sin_valid):
  - Without parity: go to IDLE and complete the word.
  - With parity: go to PARITY.
- PARITY: the next sin_valid cycle samples the parity bit, the FSM returns to IDLE and the word completes.
- Word completion loads {sin, shreg[WIDTH-1:1]} into dout in the same edge that samples the last data bit. With parity, dout loads the stored word when the parity bit is sampled.
- Output handshake:
  - A transfer occurs on a cycle with dout_valid && dout_ready.
  - dout and parity_err are stable while dout_valid is high.
  - dout_valid clears after a transfer unless a new word completes in that same edge.
- Completion coincident with a transfer: the new word loads and dout_valid stays 1.
- Completion while dout_valid && !dout_ready:
  - The new word is dropped and dout is unchanged.
  - overrun pulses high for exactly one cycle.
  - The FSM still returns to IDLE.
- abort in SHIFT/PARITY: return to IDLE next edge, no completion, dout untouched. abort has priority over sin_valid. abort in IDLE has no effect, and it overrides a coincident start.
- start outside IDLE is ignored.
- The counter is $clog2(WIDTH) bits wide and never wraps within a frame.

## Timing
- Reset values: dout = 0, dout_valid = 0, busy = 0, overrun = 0, parity_err = 0, state = IDLE, counter = 0, shreg = 0.
- Reset asserted mid-frame forces these values immediately, independent of clk.
- busy rises the edge after start and falls on the completion or abort edge.
- Latency: dout_valid is high in the cycle after the edge that samples the final bit (the last data bit, or the parity bit).
- Throughput: a new start is accepted in the cycle after busy falls. The minimum frame is WIDTH+1 cycles, or WIDTH+2 with parity.

## Configuration
- SIPO_CTRL_PARITY_EN defined:
  - The PARITY state exists and one even-parity bit follows each frame.
  - parity_err = XOR of the WIDTH data bits and the parity bit, registered alongside dout.
  - The word is delivered even when parity_err = 1.
- SIPO_CTRL_PARITY_EN undefined: no PARITY state, frames are WIDTH bits, parity_err is constant 0.

## Structure
- Package sipo_ctrl_pkg holds:
  - the state enum type and its encodings (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10);
  - the WIDTH min/max constants.
- Sub-module sipo_shreg is a WIDTH-bit shift-right register with MSB serial entry, a shift enable and async active-low reset. It is instantiated once and driven by the FSM's enable.
- FSM, counter, output register and handshake live in sipo_ctrl.

## Test plan
- Basic frame (WIDTH=8): start, then bits 1,0,1,1,0,0,1,0 on consecutive sin_valid cycles with dout_ready=1 → dout=8'h4D and dout_valid high for one cycle; busy high for exactly 8 cycles.
- Gapped strobe: the same bits with sin_valid low on alternate cycles → dout=8'h4D; the shift register is unchanged during gap cycles.
- Backpressure/overrun: dout_ready=0, frame 8'h4D, then frame 8'hA5 → dout stays 8'h4D, overrun pulses once on the second completion; raising dout_ready drops dout_valid.
- Back-to-back with transfer: complete frame 8'h3C while an earlier word is handshaken in the same edge → dout=8'h3C, dout_valid stays 1, overrun stays 0.
- Abort and reset: abort after 4 bits → IDLE, no dout_valid; assert rst_n=0 mid-frame → all outputs 0 immediately; a following start and a full frame of bits decode correctly.
- Parity (SIPO_CTRL_PARITY_EN): frame 8'h4D with parity bit 0 → parity_err=0; with parity bit 1 → parity_err=1 and dout still 8'h4D.
